// File: rtl/fixed_exp_range_reduce.sv
// fixed_exp_range_reduce
// Splits a signed Q7.7 argument x into x = k*ln2 + f (0 <= f < ln2) using a
// restoring divider that retires one quotient bit per clock.
// k feeds the power-of-two scaling stage; f is the unsigned Q3.7 residue for
// the exponential core.
// Optional build macro: FIXED_EXP_RR_RANGE_FLAG_EN builds the ovf/unf range
// comparators. When it is left undefined, ovf and unf are tied to zero.
module fixed_exp_range_reduce #(
  parameter logic [6:0] LN2_Q7 = 7'd89,
  parameter int         XW     = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] x_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    k_out,
  output logic [9:0]    f_out,
  output logic          ovf,
  output logic          unf
);

  localparam int CW = $clog2(XW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;

  logic            sign_r;
  logic [XW-1:0]   dividend_r;
  logic [7:0]      rem_r;
  logic [XW-1:0]   quot_r;
  logic [CW-1:0]   cnt_r;

  logic            in_ready_r;
  logic            out_valid_r;
  logic [7:0]      k_out_r;
  logic [9:0]      f_out_r;
  logic            ovf_r;
  logic            unf_r;

  // combinational helpers
  logic [XW-1:0]   abs_x_s;
  logic [8:0]      rem_shift_s;
  logic            rem_ge_s;
  logic [7:0]      rem_step_s;
  logic signed [XW:0] k_full_s;
  logic [9:0]      f_fix_s;
  logic            ovf_s;
  logic            unf_s;

  // Magnitude of the input; the most negative code maps to 2^(XW-1) unsigned.
  always_comb begin
    abs_x_s = x_in;
    if (x_in[XW-1]) begin
      abs_x_s = (~x_in) + {{(XW-1){1'b0}}, 1'b1};
    end else begin
      abs_x_s = x_in;
    end
  end

  // One restoring-division trial: shift in the next dividend bit, subtract ln2 if it fits.
  always_comb begin
    rem_shift_s = {rem_r, dividend_r[cnt_r]};
    rem_ge_s    = (rem_shift_s >= {2'b00, LN2_Q7});
    rem_step_s  = 8'(rem_shift_s);
    if (rem_ge_s) begin
      rem_step_s = 8'(rem_shift_s - {2'b00, LN2_Q7});
    end else begin
      rem_step_s = 8'(rem_shift_s);
    end
  end

  // Sign fix-up: a negative argument with nonzero remainder borrows one ln2
  // so the residue stays in [0, ln2).
  always_comb begin
    k_full_s = $signed({1'b0, quot_r});
    f_fix_s  = {2'b00, rem_r};
    if (!sign_r) begin
      k_full_s = $signed({1'b0, quot_r});
      f_fix_s  = {2'b00, rem_r};
    end else if (rem_r == 8'd0) begin
      k_full_s = -$signed({1'b0, quot_r});
      f_fix_s  = 10'd0;
    end else begin
      // ~q in two's complement equals -q-1
      k_full_s = $signed(~{1'b0, quot_r});
      f_fix_s  = {3'b000, LN2_Q7} - {2'b00, rem_r};
    end
  end

`ifdef FIXED_EXP_RR_RANGE_FLAG_EN
  localparam logic signed [XW:0] K_OVF = (XW+1)'(4);
  localparam logic signed [XW:0] K_UNF = -((XW+1)'(5));

  // Range flags: core output times 2^k leaves the Q5.5 range.
  always_comb begin
    ovf_s = (k_full_s > K_OVF);
    unf_s = (k_full_s < K_UNF);
  end
`else
  // Range comparators are not built in this configuration.
  always_comb begin
    ovf_s = 1'b0;
    unf_s = 1'b0;
  end
`endif

  // Next-state logic for the IDLE -> DIV -> FIX -> DONE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = DIV;
        end else begin
          state_s = IDLE;
        end
      end
      DIV: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_s = FIX;
        end else begin
          state_s = DIV;
        end
      end
      FIX: begin
        state_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; in_ready is registered so it tracks IDLE exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == IDLE);
    end
  end

  // Divider datapath and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_r      <= 1'b0;
      dividend_r  <= {XW{1'b0}};
      rem_r       <= 8'd0;
      quot_r      <= {XW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      k_out_r     <= 8'd0;
      f_out_r     <= 10'd0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sign_r     <= x_in[XW-1];
            dividend_r <= abs_x_s;
            rem_r      <= 8'd0;
            quot_r     <= {XW{1'b0}};
            cnt_r      <= CW'(XW - 1);
          end else begin
            cnt_r      <= cnt_r;
          end
        end
        DIV: begin
          rem_r         <= rem_step_s;
          quot_r[cnt_r] <= rem_ge_s;
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cnt_r <= cnt_r;
          end
        end
        FIX: begin
          // |q| never exceeds 93, so the low byte carries the full signed k.
          k_out_r     <= 8'(k_full_s);
          f_out_r     <= f_fix_s;
          ovf_r       <= ovf_s;
          unf_r       <= unf_s;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign k_out     = k_out_r;
  assign f_out     = f_out_r;
  assign ovf       = ovf_r;
  assign unf       = unf_r;

endmodule

// File: tb/tb_fixed_exp_range_reduce.sv
// Directed self-checking bench for fixed_exp_range_reduce.
module tb_fixed_exp_range_reduce;

`ifdef FIXED_EXP_RR_RANGE_FLAG_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] x_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  k_out;
  logic [9:0]  f_out;
  logic        ovf;
  logic        unf;

  int tests;
  int fails;

  fixed_exp_range_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .k_out     (k_out),
    .f_out     (f_out),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present x and wait for the accept edge; afterwards scramble x_in.
  task automatic accept(input logic [13:0] x, input string tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    x_in     = x;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, " in_ready before accept"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    x_in     = ~x;
    check({tag, " in_ready after accept"}, {31'd0, in_ready}, 32'd0);
  endtask

  // Count edges after the accept edge until out_valid; must be 15.
  task automatic wait_valid(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd15);
  endtask

  task automatic check_out(input string tag, input logic [7:0] ek, input logic [9:0] ef,
                           input logic eo, input logic eu);
    check({tag, " k_out"}, {24'd0, k_out}, {24'd0, ek});
    check({tag, " f_out"}, {22'd0, f_out}, {22'd0, ef});
    check({tag, " ovf"},   {31'd0, ovf},   {31'd0, eo});
    check({tag, " unf"},   {31'd0, unf},   {31'd0, eu});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready after handshake"},  {31'd0, in_ready},  32'd1);
  endtask

  task automatic run_op(input logic [13:0] x, input logic [7:0] ek, input logic [9:0] ef,
                        input logic eo, input logic eu, input string tag);
    accept(x, tag);
    wait_valid(tag);
    check_out(tag, ek, ef, eo, eu);
    handshake(tag);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = 14'd0;
    #12;
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check_out("reset", 8'd0, 10'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Main function, hand-computed: k = floor(x/89), f = x - 89k.
    run_op(14'd0,                8'd0,            10'd0,  1'b0,  1'b0,  "x=0");
    run_op(14'd128,              8'd1,            10'd39, 1'b0,  1'b0,  "x=128");
    run_op(14'h3F80 /* -128 */,  8'hFE /* -2 */,  10'd50, 1'b0,  1'b0,  "x=-128");
    run_op(14'd89,               8'd1,            10'd0,  1'b0,  1'b0,  "x=89");
    run_op(14'h3FA7 /* -89 */,   8'hFF /* -1 */,  10'd0,  1'b0,  1'b0,  "x=-89");
    run_op(14'd8191,             8'd92,           10'd3,  FLAGS, 1'b0,  "x=8191");
    run_op(14'h2000 /* -8192 */, 8'hA3 /* -93 */, 10'd85, 1'b0,  FLAGS, "x=-8192");
    run_op(14'd445 /* 5*89 */,   8'd5,            10'd0,  FLAGS, 1'b0,  "x=445");
    run_op(14'h3E43 /* -445 */,  8'hFB /* -5 */,  10'd0,  1'b0,  1'b0,  "x=-445");

    // Backpressure: result held for 20 cycles, stray in_valid ignored.
    accept(14'd300, "bp");
    wait_valid("bp");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid = 1'b1;
        x_in     = 14'h3F80;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
      check("bp hold in_ready",  {31'd0, in_ready},  32'd0);
      check_out("bp hold", 8'd3, 10'd33, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    handshake("bp");
    for (int i = 0; i < 18; i++) begin
      tick();
    end
    check("bp no stray result", {31'd0, out_valid}, 32'd0);
    check("bp still idle",      {31'd0, in_ready},  32'd1);

    // Reset during the 7th DIV cycle, then a clean operation.
    accept(14'd1000, "rst");
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst no result", {31'd0, out_valid}, 32'd0);
    run_op(14'd256, 8'd2, 10'd78, 1'b0, 1'b0, "x=256");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
